div_seq: RTL and testbench

Parametrised sequential integer divider for the datapath's DIV/DIVU instructions. It supports signed and unsigned modes, uses a radix-2 restoring algorithm with a fixed latency, and takes one quotient bit per cycle. It sits beside the ALU, is started by the control unit, and writes the HI register (remainder) and the LO register (quotient). It reports division by zero instead of hanging.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_if.sv | 28 ++
 rtl/div_step.sv | 33 +++
 rtl/div_seq.sv | 145 ++++++++++++++
 tb/tb_div_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared divider definitions: FSM states, divide-by-zero quotient fill and the
// default datapath width also used by the multiplier and control unit.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Divide-by-zero quotient is this bit replicated across the result word.
  localparam logic DIV0_QUO_FILL = 1'b1;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface div_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude, keep or restore and record the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  localparam int unsigned SH_W = 2 * WIDTH + 1;

  logic [SH_W-1:0]  shifted;
  logic [WIDTH+1:0] diff;

  // Extra guard bit on the subtraction gives the sign of the trial result.
  always_comb begin
    shifted = {rem_i, quo_i} << 1;
    diff    = {1'b0, shifted[SH_W-1:WIDTH]} - {2'b00, dvs_i};
    if (diff[WIDTH+1]) begin
      rem_o = shifted[SH_W-1:WIDTH];
      quo_o = shifted[WIDTH-1:0];
    end else begin
      rem_o = diff[WIDTH:0];
      quo_o = shifted[WIDTH-1:0] | WIDTH'(1);
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider: operand conditioning, one restoring step
// per cycle, sign fix-up, and HI (remainder) / LO (quotient) result registers.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic  clock,
  input logic  reset,
  div_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // Magnitudes are unsigned, so negating MIN yields 2^(WIDTH-1) correctly.
  always_comb begin
    a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    a_mag = a_neg ? -bus.dividend : bus.dividend;
    b_mag = b_neg ? -bus.divisor : bus.divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_zero_d = 1'b0;
          // A zero divisor answers immediately without leaving IDLE.
          if (bus.divisor == '0) begin
            div_zero_d = 1'b1;
            lo_d       = {WIDTH{DIV0_QUO_FILL}};
            hi_d       = bus.dividend;
            done_d     = 1'b1;
          end else begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = CNT_W'(WIDTH);
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq at WIDTH=32 and WIDTH=8: directed cases plus a
// random sweep checked against plain integer arithmetic.
module tb_div_seq;
  import div_pkg::*;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          done_cyc;
    int          busy_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_run32 = 0;
  int   busy_run8 = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  div_if #(.WIDTH(32)) bus32 ();
  div_if #(.WIDTH(8))  bus8 ();

  div_seq #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
  div_seq #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: integer division truncating toward zero, remainder takes dividend sign.
  function automatic void model(input int unsigned w, input bit s, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] lo,
                                output logic [31:0] hi, output bit dz);
    longint mask, av, bv;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    if (s && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
    if (s && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    dz = (bv == 0);
    if (dz) begin
      lo = 32'(mask);
      hi = 32'(longint'(a) & mask);
    end else begin
      lo = 32'((av / bv) & mask);
      hi = 32'((av % bv) & mask);
    end
  endfunction

  // Waits for idle, presents one request and (optionally) records its expected result.
  task automatic issue(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input bit edz,
                       input bit push);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    while ((w8 ? bus8.busy : bus32.busy) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 32'd1, 32'd0);
    lat        = edz ? 0 : (w8 ? 9 : 33);
    e.lo       = elo;
    e.hi       = ehi;
    e.dz       = edz;
    e.done_cyc = cyc + 1 + lat;
    e.busy_cyc = lat;
    if (w8) begin
      bus8.start = 1'b1; bus8.signed_op = s; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
      if (push) q8.push_back(e);
    end else begin
      bus32.start = 1'b1; bus32.signed_op = s; bus32.dividend = a; bus32.divisor = b;
      if (push) q32.push_back(e);
    end
    @(negedge clock);
    bus8.start  = 1'b0;
    bus32.start = 1'b0;
  endtask

  task automatic rand_op(input bit w8);
    logic [31:0] a, b, lo, hi;
    bit          s, dz;
    s = 1'($urandom_range(0, 1));
    a = $urandom;
    case ($urandom_range(0, 7))
      0:       b = 32'h0;
      1:       b = 32'hFFFF_FFFF;
      2:       b = $urandom_range(1, 15);
      3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      default: b = $urandom;
    endcase
    if (w8) begin
      a = a & 32'hFF;
      b = b & 32'hFF;
      if (a == 32'h8000_0000 & 32'hFF) a = 32'h80;
    end
    model(w8 ? 8 : 32, s, a, b, lo, hi, dz);
    issue(w8, s, a, b, lo, hi, dz, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus32.busy || bus8.busy || q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      busy_run32 = 0;
    end else if (bus32.done) begin
      if (q32.size() == 0) begin
        chk("spurious_done32", 32'd1, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("lo32", bus32.lo_out, e32.lo);
        chk("hi32", bus32.hi_out, e32.hi);
        chk("div_zero32", 32'(bus32.div_zero), 32'(e32.dz));
        chk("latency32", 32'(cyc), 32'(e32.done_cyc));
        chk("busy_in_done32", 32'(bus32.busy), 32'd0);
        chk("busy_len32", 32'(busy_run32), 32'(e32.busy_cyc));
      end
      busy_run32 = 0;
    end else if (bus32.busy) begin
      busy_run32++;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      busy_run8 = 0;
    end else if (bus8.done) begin
      if (q8.size() == 0) begin
        chk("spurious_done8", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("lo8", {24'h0, bus8.lo_out}, e8.lo);
        chk("hi8", {24'h0, bus8.hi_out}, e8.hi);
        chk("div_zero8", 32'(bus8.div_zero), 32'(e8.dz));
        chk("latency8", 32'(cyc), 32'(e8.done_cyc));
        chk("busy_in_done8", 32'(bus8.busy), 32'd0);
        chk("busy_len8", 32'(busy_run8), 32'(e8.busy_cyc));
      end
      busy_run8 = 0;
    end else if (bus8.busy) begin
      busy_run8++;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus32.start = 1'b0; bus32.signed_op = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
    bus8.start  = 1'b0; bus8.signed_op  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy32", 32'(bus32.busy), 32'd0);
    chk("rst_done32", 32'(bus32.done), 32'd0);
    chk("rst_dz32", 32'(bus32.div_zero), 32'd0);
    chk("rst_hi32", bus32.hi_out, 32'd0);
    chk("rst_lo32", bus32.lo_out, 32'd0);
    chk("rst_busy8", 32'(bus8.busy), 32'd0);
    chk("rst_lo8", {24'h0, bus8.lo_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases issued back to back, so each start lands in the prior done cycle.
    issue(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1);
    issue(0, 1, 32'd7, 32'd3, 32'd2, 32'd1, 0, 1);
    issue(0, 1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd1, 0, 1);
    issue(0, 1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1);
    issue(0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF, 0, 1);
    issue(0, 0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 1);
    issue(0, 1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1, 1);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 1);
    issue(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1);
    wait_idle();

    // Start pulse and operand changes mid-operation must not disturb the result.
    issue(0, 0, 32'd1000, 32'd9, 32'd111, 32'd1, 0, 1);
    repeat (5) @(negedge clock);
    bus32.start = 1'b1; bus32.dividend = $urandom; bus32.divisor = 32'd3; bus32.signed_op = 1'b1;
    @(negedge clock);
    bus32.start = 1'b0; bus32.dividend = $urandom; bus32.divisor = $urandom;
    wait_idle();

    // Reset landing on the tenth CALC edge aborts with no done.
    issue(0, 0, 32'd5000, 32'd7, 32'd0, 32'd0, 0, 0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy32", 32'(bus32.busy), 32'd0);
    chk("abort_done32", 32'(bus32.done), 32'd0);
    chk("abort_dz32", 32'(bus32.div_zero), 32'd0);
    chk("abort_hi32", bus32.hi_out, 32'd0);
    chk("abort_lo32", bus32.lo_out, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_idle32", 32'(bus32.busy), 32'd0);

    for (int i = 0; i < 150; i++) rand_op(1'b0);
    wait_idle();

    issue(1, 0, 32'd255, 32'd16, 32'd15, 32'd15, 0, 1);
    for (int i = 0; i < 100; i++) rand_op(1'b1);
    wait_idle();
    repeat (5) @(negedge clock);

    chk("q32_drained", 32'(q32.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
